// File: rtl/fp_arb_pkg.sv
// Shared definitions for the round-robin front end of the single-precision multiplier.
package fp_arb_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    localparam int W_DEFAULT = 32;

    // Every strobe and acknowledge in this block is active-high.
    localparam logic STB_ON  = 1'b1;
    localparam logic STB_OFF = 1'b0;
    localparam logic ACK_ON  = 1'b1;
    localparam logic ACK_OFF = 1'b0;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, counting modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    always_comb begin
        logic found;
        int   k;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IW'(k);
            end
        end
    end
endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one handshaked FP multiplier among N requesters; one transaction in flight,
// round-robin fairness, operands and result held stable between grants.
module fp_mul_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 req_stb,
    input  logic [N*W-1:0]               req_a,
    input  logic [N*W-1:0]               req_b,
    output logic [N-1:0]                 req_ack,
    output logic [W-1:0]                 res_z,
    output logic [N-1:0]                 res_stb,
    input  logic [N-1:0]                 res_ack,
    output logic [W-1:0]                 mul_a,
    output logic [W-1:0]                 mul_b,
    output logic                         mul_a_stb,
    output logic                         mul_b_stb,
    input  logic                         mul_a_ack,
    input  logic                         mul_b_ack,
    input  logic [W-1:0]                 mul_z,
    input  logic                         mul_z_stb,
    output logic                         mul_z_ack,
    output logic                         busy,
    output logic [$clog2(N)-1:0]         grant_id
);
    localparam int IW = $clog2(N);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [N-1:0]  rr_grant;
    logic [IW-1:0] rr_idx;
    logic          a_seen;
    logic          b_seen;

    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .req   (req_stb),
        .ptr   (ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // A lowered strobe means that operand's acknowledge has already been taken.
    assign a_seen = (mul_a_stb == STB_OFF) || (mul_a_ack == ACK_ON);
    assign b_seen = (mul_b_stb == STB_OFF) || (mul_b_ack == ACK_ON);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            req_ack   <= '0;
            res_stb   <= '0;
            mul_a_stb <= STB_OFF;
            mul_b_stb <= STB_OFF;
            mul_z_ack <= ACK_OFF;
            busy      <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            res_z     <= '0;
        end else begin
            req_ack   <= '0;
            mul_z_ack <= ACK_OFF;
            case (state)
                IDLE: begin
                    if (|req_stb) begin
                        mul_a     <= req_a[int'(rr_idx)*W +: W];
                        mul_b     <= req_b[int'(rr_idx)*W +: W];
                        req_ack   <= rr_grant;
                        grant_id  <= rr_idx;
                        mul_a_stb <= STB_ON;
                        mul_b_stb <= STB_ON;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mul_a_ack == ACK_ON) mul_a_stb <= STB_OFF;
                    if (mul_b_ack == ACK_ON) mul_b_stb <= STB_OFF;
                    if (a_seen && b_seen) state <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (mul_z_stb == STB_ON) begin
                        res_z             <= mul_z;
                        mul_z_ack         <= ACK_ON;
                        res_stb[grant_id] <= STB_ON;
                        state             <= DELIVER;
                    end
                end
                DELIVER: begin
                    // Only the owner's acknowledge retires the result.
                    if (res_ack[grant_id] == ACK_ON) begin
                        res_stb <= '0;
                        ptr     <= (grant_id == IW'(N-1)) ? '0 : grant_id + 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: handshaked multiplier model, requester/consumer driver, scoreboard.
module tb_fp_mul_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_stb;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ack;
    logic [W-1:0]     res_z;
    logic [N-1:0]     res_stb;
    logic [N-1:0]     res_ack;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic             mul_a_stb;
    logic             mul_b_stb;
    logic             mul_a_ack;
    logic             mul_b_ack;
    logic [W-1:0]     mul_z;
    logic             mul_z_stb;
    logic             mul_z_ack;
    logic             busy;
    logic [1:0]       grant_id;

    fp_mul_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_stb(req_stb), .req_a(req_a), .req_b(req_b), .req_ack(req_ack),
        .res_z(res_z), .res_stb(res_stb), .res_ack(res_ack),
        .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
        .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
        .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
        .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact-operand single-precision product (normal numbers, truncating).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // Multiplier model with programmable acknowledge and result latency.
    int          a_dly, b_dly, z_dly;
    int          a_cnt, b_cnt, z_cnt;
    logic        a_done, b_done, z_busy;
    logic [31:0] op_a, op_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a_ack <= 1'b0; mul_b_ack <= 1'b0; mul_z_stb <= 1'b0; mul_z <= '0;
            a_done <= 1'b0; b_done <= 1'b0; z_busy <= 1'b0;
            a_cnt <= 0; b_cnt <= 0; z_cnt <= 0; op_a <= '0; op_b <= '0;
        end else begin
            if (mul_a_stb && !a_done) begin
                if (a_cnt >= a_dly) begin
                    mul_a_ack <= 1'b1; a_done <= 1'b1; op_a <= mul_a;
                end else a_cnt <= a_cnt + 1;
            end else mul_a_ack <= 1'b0;
            if (mul_b_stb && !b_done) begin
                if (b_cnt >= b_dly) begin
                    mul_b_ack <= 1'b1; b_done <= 1'b1; op_b <= mul_b;
                end else b_cnt <= b_cnt + 1;
            end else mul_b_ack <= 1'b0;
            if (a_done && b_done && !z_busy) begin
                if (z_cnt >= z_dly) begin
                    mul_z_stb <= 1'b1; mul_z <= fmul(op_a, op_b); z_busy <= 1'b1;
                end else z_cnt <= z_cnt + 1;
            end
            if (mul_z_stb && mul_z_ack) begin
                mul_z_stb <= 1'b0; a_done <= 1'b0; b_done <= 1'b0; z_busy <= 1'b0;
                a_cnt <= 0; b_cnt <= 0; z_cnt <= 0;
            end
        end
    end

    typedef struct { int k; logic [31:0] a; logic [31:0] b; logic [31:0] z; } vec_t;
    typedef struct { int k; logic [31:0] z; } sb_t;

    vec_t        vecs[19];
    sb_t         sb[$];
    int          grant_log[$];
    logic [31:0] exp_of[N];
    sb_t         cur;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdly, hold, last_rack;
    int   a_rise, b_rise, a_hi, b_hi;
    logic in_deliver, poke, gap_en, chk_gap;
    logic prev_zack, prev_a_stb, prev_b_stb;
    logic [N-1:0] prev_req_ack;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic chk_order(input string name, input int pos, input int exp);
        if (pos < grant_log.size()) chk(name, grant_log[pos], exp);
        else chk(name, 32'hFFFF_FFFF, exp);
    endtask

    task automatic issue(input int v);
        vec_t x;
        x = vecs[v];
        req_stb[x.k]        = 1'b1;
        req_a[x.k*W +: W]   = x.a;
        req_b[x.k*W +: W]   = x.b;
        exp_of[x.k]         = x.z;
    endtask

    // One clock: observe outputs at the falling edge, then react as requesters/consumers.
    task automatic step();
        @(negedge clk);
        cyc++;
        res_ack = '0;
        if (req_ack != '0) begin
            int k;
            k = 0;
            for (int i = 0; i < N; i++) if (req_ack[i]) k = i;
            chk("req_ack_onehot", 32'($onehot(req_ack)), 1);
            chk("req_ack_pulse", 32'(prev_req_ack), 0);
            chk("req_ack_on_stb", 32'(req_stb[k]), 1);
            chk("grant_id", 32'(grant_id), k);
            chk("ack_outside_deliver", 32'(res_stb), 0);
            if (chk_gap) begin
                chk("regrant_gap", cyc - last_rack, 2);
                chk_gap = 1'b0;
            end
            req_stb[k] = 1'b0;
            grant_log.push_back(k);
            sb.push_back('{k, exp_of[k]});
        end
        prev_req_ack = req_ack;
        if (mul_z_ack) chk("mul_z_ack_pulse", 32'(prev_zack), 0);
        prev_zack = mul_z_ack;
        if (mul_a_stb && !prev_a_stb) a_rise++;
        if (mul_b_stb && !prev_b_stb) b_rise++;
        if (mul_a_stb) a_hi++;
        if (mul_b_stb) b_hi++;
        prev_a_stb = mul_a_stb;
        prev_b_stb = mul_b_stb;
        if (res_stb != '0) begin
            if (!in_deliver) begin
                if (sb.size() == 0) chk("res_stb_unexpected", 32'(res_stb), 0);
                else begin
                    cur = sb.pop_front();
                    in_deliver = 1'b1;
                    hold = 0;
                end
            end
            if (in_deliver) begin
                chk("res_stb_owner", 32'(res_stb), 32'd1 << cur.k);
                chk("res_z", res_z, cur.z);
                hold++;
                if (hold > rdly) begin
                    res_ack[cur.k] = 1'b1;
                    last_rack = cyc;
                    if (gap_en) begin chk_gap = 1'b1; gap_en = 1'b0; end
                end else if (poke && hold == 3) begin
                    res_ack[(cur.k + 1) % N] = 1'b1;
                end
            end
        end else if (in_deliver) begin
            in_deliver = 1'b0;
            chk("res_hold", hold, rdly + 1);
        end
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while ((req_stb != '0 || sb.size() != 0 || busy || in_deliver) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("timeout", 1, 0);
        step();
    endtask

    initial begin
        vecs[0]  = '{1, 32'h40000000, 32'h40400000, 32'h40C00000};
        vecs[1]  = '{2, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
        vecs[2]  = '{3, 32'hC0000000, 32'h3F000000, 32'hBF800000};
        vecs[3]  = '{0, 32'h40800000, 32'h3E800000, 32'h3F800000};
        vecs[4]  = '{3, 32'h40400000, 32'h40400000, 32'h41100000};
        vecs[5]  = '{0, 32'h3F800000, 32'hC0E00000, 32'hC0E00000};
        vecs[6]  = '{1, 32'h40400000, 32'h40000000, 32'h40C00000};
        vecs[7]  = '{2, 32'h3E800000, 32'h40800000, 32'h3F800000};
        vecs[8]  = '{3, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
        vecs[9]  = '{0, 32'h40400000, 32'h40400000, 32'h41100000};
        vecs[10] = '{2, 32'hC0E00000, 32'h3F800000, 32'hC0E00000};
        vecs[11] = '{1, 32'hC0000000, 32'h3F000000, 32'hBF800000};
        vecs[12] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000};
        vecs[13] = '{1, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
        vecs[14] = '{3, 32'h40800000, 32'h3E800000, 32'h3F800000};
        vecs[15] = '{2, 32'h40400000, 32'h40400000, 32'h41100000};
        vecs[16] = '{1, 32'h40000000, 32'h40400000, 32'h40C00000};
        vecs[17] = '{3, 32'hC0000000, 32'h3F000000, 32'hBF800000};
        vecs[18] = '{1, 32'h3F800000, 32'hC0E00000, 32'hC0E00000};

        req_stb = '0; req_a = '0; req_b = '0; res_ack = '0;
        a_dly = 0; b_dly = 0; z_dly = 2; rdly = 2;
        hold = 0; last_rack = 0; a_rise = 0; b_rise = 0; a_hi = 0; b_hi = 0;
        in_deliver = 1'b0; poke = 1'b0; gap_en = 1'b0; chk_gap = 1'b0;
        prev_zack = 1'b0; prev_a_stb = 1'b0; prev_b_stb = 1'b0; prev_req_ack = '0;
        for (int i = 0; i < N; i++) exp_of[i] = '0;

        rst = 1'b0;
        step(); step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ack", 32'(req_ack), 0);
        chk("rst_res_stb", 32'(res_stb), 0);
        chk("rst_mul_a_stb", 32'(mul_a_stb), 0);
        chk("rst_mul_b_stb", 32'(mul_b_stb), 0);
        chk("rst_mul_z_ack", 32'(mul_z_ack), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_res_z", res_z, 0);
        rst = 1'b1;
        step();

        // Single request from requester 1: 2.0 * 3.0.
        issue(0); run(100);
        chk_order("single_grant", 0, 1);
        chk("single_count", grant_log.size(), 1);
        grant_log.delete();

        // Requester 2 alone, then {3,0} with ptr at 3 exercises the wrap.
        issue(1); run(100);
        grant_log.delete();
        issue(2); issue(3); run(200);
        chk_order("wrap_first", 0, 3);
        chk_order("wrap_second", 1, 0);
        grant_log.delete();
        issue(4); run(100);
        grant_log.delete();

        // All four requesting with ptr at 0, then {0,2}.
        for (int v = 5; v <= 8; v++) issue(v);
        run(400);
        for (int i = 0; i < N; i++) chk_order("all_four", i, i);
        grant_log.delete();
        issue(9); issue(10); run(200);
        chk_order("pair_first", 0, 0);
        chk_order("pair_second", 1, 2);
        grant_log.delete();

        // Operand acknowledges skewed by three cycles.
        a_dly = 0; b_dly = 3;
        a_rise = 0; b_rise = 0; a_hi = 0; b_hi = 0;
        issue(11); run(100);
        chk("skew_a_rises", a_rise, 1);
        chk("skew_b_rises", b_rise, 1);
        chk("skew_a_high", a_hi, 2);
        chk("skew_b_high", b_hi, 5);
        chk_order("skew_grant", 0, 1);
        grant_log.delete();
        a_dly = 1; b_dly = 0;

        // Slow consumer with other requests queued; non-owner res_ack is poked meanwhile.
        rdly = 10; poke = 1'b1; gap_en = 1'b1;
        issue(12);
        begin
            int n;
            n = 0;
            while (grant_log.size() == 0 && n < 20) begin step(); n++; end
            if (n >= 20) chk("slow_first_grant_timeout", 1, 0);
        end
        issue(13); issue(14);
        run(400);
        chk_order("slow_0", 0, 0);
        chk_order("slow_1", 1, 1);
        chk_order("slow_2", 2, 3);
        grant_log.delete();
        rdly = 2; poke = 1'b0;

        // Move ptr to 3, then abandon a transaction with a reset in WAIT_RES.
        issue(15); run(100);
        grant_log.delete();
        z_dly = 8;
        issue(16);
        begin
            int n;
            n = 0;
            step();
            while (!(busy && !mul_a_stb && !mul_b_stb && res_stb == '0) && n < 50) begin
                step(); n++;
            end
            if (n >= 50) chk("wait_res_timeout", 1, 0);
        end
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_mul_a_stb", 32'(mul_a_stb), 0);
        chk("arst_mul_b_stb", 32'(mul_b_stb), 0);
        chk("arst_mul_z_ack", 32'(mul_z_ack), 0);
        chk("arst_res_stb", 32'(res_stb), 0);
        chk("arst_grant_id", 32'(grant_id), 0);
        chk("arst_mul_a", mul_a, 0);
        chk("arst_res_z", res_z, 0);
        sb.delete();
        grant_log.delete();
        in_deliver = 1'b0;
        step(); step();
        rst = 1'b1;
        z_dly = 1;
        repeat (15) step();
        chk("no_res_after_reset", 32'(res_stb), 0);
        issue(17); issue(18); run(200);
        chk_order("post_reset_first", 0, 1);
        chk_order("post_reset_second", 1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
